keypad_scanner: RTL

Scans the 4x4 matrix keypad, debounces it, and emits one key code per press. It sits directly upstream of the calculator's input stage. It drives the keypad columns and reads the rows, so the input stage receives clean `key_code`/`key_valid` events instead of raw row/column lines. Rows are active-low with pull-ups; exactly one column is driven low at a time.

---
 rtl/calc_pkg.sv | 44 ++++
 rtl/row_sync.sv | 22 ++
 rtl/keypad_scanner.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared keypad codes, key map and scanner enums
package calc_pkg;

  localparam logic [3:0] KEY_STAR = 4'hE;
  localparam logic [3:0] KEY_HASH = 4'hF;

  typedef enum logic [1:0] {
    SCAN_NONE,
    SCAN_SINGLE,
    SCAN_MULTI
  } scan_result_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DEBOUNCE,
    ST_PRESSED,
    ST_RELEASE
  } state_e;

  // Row 0 is the top row; column index follows the low bit of col.
  function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] code;
    case ({r, c})
      4'h0:    code = 4'h1;
      4'h1:    code = 4'h2;
      4'h2:    code = 4'h3;
      4'h3:    code = 4'hA;
      4'h4:    code = 4'h4;
      4'h5:    code = 4'h5;
      4'h6:    code = 4'h6;
      4'h7:    code = 4'hB;
      4'h8:    code = 4'h7;
      4'h9:    code = 4'h8;
      4'hA:    code = 4'h9;
      4'hB:    code = 4'hC;
      4'hC:    code = KEY_STAR;
      4'hD:    code = 4'h0;
      4'hE:    code = KEY_HASH;
      default: code = 4'hD;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/row_sync.sv
// rtl/row_sync.sv - 4-bit two-flop synchronizer for the keypad rows
module row_sync (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] d,
  output logic [3:0] q
);

  logic [3:0] meta;

  // Resets to all-high so nothing looks pressed until real samples arrive.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta <= 4'b1111;
      q    <= 4'b1111;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 keypad column scan, debounce and key event generation
module keypad_scanner
  import calc_pkg::*;
#(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int              DIV_W    = $clog2(SCAN_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [3:0]      DEB_N    = 4'(DEBOUNCE_SCANS);

  logic [3:0]       row_s;
  logic [DIV_W-1:0] div;
  logic [1:0]       col_idx;
  logic [1:0]       hits;
  logic [3:0]       hit_code;
  logic             dwell_end;
  logic             scan_done;
  logic [2:0]       col_pop;
  logic [1:0]       col_row;
  logic [2:0]       tot;
  logic [1:0]       hits_nxt;
  logic [3:0]       code_nxt;
  scan_result_e     result;
  state_e           state, state_nxt;
  logic [3:0]       cnt, cnt_nxt;
  logic [3:0]       cand, cand_nxt;
  logic [3:0]       code_out_nxt;
  logic             valid_nxt, held_nxt;

  row_sync u_row_sync (
    .clk   (clk),
    .reset (reset),
    .d     (row),
    .q     (row_s)
  );

  assign dwell_end = (div == DIV_LAST);
  assign scan_done = dwell_end && (col_idx == 2'd3);
  assign col       = ~(4'b0001 << col_idx);

  // Fold the current column into the running scan; hits saturates at 2 (MULTI).
  always_comb begin
    col_pop = '0;
    col_row = '0;
    for (int i = 3; i >= 0; i--) begin
      if (!row_s[i]) begin
        col_pop = col_pop + 3'd1;
        col_row = 2'(i);
      end
    end
    tot      = {1'b0, hits} + col_pop;
    hits_nxt = (tot >= 3'd2) ? 2'd2 : tot[1:0];
    code_nxt = (hits == 2'd0 && col_pop == 3'd1) ? key_map(col_row, col_idx) : hit_code;
    if (hits_nxt == 2'd0)      result = SCAN_NONE;
    else if (hits_nxt == 2'd1) result = SCAN_SINGLE;
    else                       result = SCAN_MULTI;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div      <= '0;
      col_idx  <= '0;
      hits     <= '0;
      hit_code <= '0;
    end else if (dwell_end) begin
      div     <= '0;
      col_idx <= col_idx + 2'd1;
      if (col_idx == 2'd3) begin
        hits     <= '0;
        hit_code <= '0;
      end else begin
        hits     <= hits_nxt;
        hit_code <= code_nxt;
      end
    end else begin
      div <= div + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      cand      <= '0;
      key_code  <= '0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      cand      <= cand_nxt;
      key_code  <= code_out_nxt;
      key_valid <= valid_nxt;
      key_held  <= held_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    cand_nxt     = cand;
    code_out_nxt = key_code;
    valid_nxt    = 1'b0;
    held_nxt     = key_held;
    if (scan_done) begin
      case (state)
        ST_IDLE: begin
          if (result == SCAN_SINGLE) begin
            cand_nxt = code_nxt;
            if (DEBOUNCE_SCANS == 1) begin
              state_nxt    = ST_PRESSED;
              cnt_nxt      = '0;
              code_out_nxt = code_nxt;
              valid_nxt    = 1'b1;
              held_nxt     = 1'b1;
            end else begin
              state_nxt = ST_DEBOUNCE;
              cnt_nxt   = 4'd1;
            end
          end
        end
        ST_DEBOUNCE: begin
          if (result == SCAN_SINGLE && code_nxt == cand) begin
            cnt_nxt = cnt + 4'd1;
            if (cnt + 4'd1 == DEB_N) begin
              state_nxt    = ST_PRESSED;
              cnt_nxt      = '0;
              code_out_nxt = cand;
              valid_nxt    = 1'b1;
              held_nxt     = 1'b1;
            end
          end else begin
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
          end
        end
        ST_PRESSED: begin
          if (result == SCAN_NONE) begin
            if (DEBOUNCE_SCANS == 1) begin
              state_nxt = ST_IDLE;
              cnt_nxt   = '0;
              held_nxt  = 1'b0;
            end else begin
              state_nxt = ST_RELEASE;
              cnt_nxt   = 4'd1;
            end
          end
        end
        default: begin
          if (result == SCAN_NONE) begin
            cnt_nxt = cnt + 4'd1;
            if (cnt + 4'd1 == DEB_N) begin
              state_nxt = ST_IDLE;
              cnt_nxt   = '0;
              held_nxt  = 1'b0;
            end
          end else begin
            state_nxt = ST_PRESSED;
            cnt_nxt   = '0;
          end
        end
      endcase
    end
  end

endmodule
